// File: rtl/bist_pkg.sv
// Shared types and defaults for the multi-channel BIST sequencer.
package bist_pkg;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_INIT_CYCLES = 4;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_init = 2'd1,
      st_run  = 2'd2,
      st_fin  = 2'd3
   } state_t;

endpackage

// File: rtl/bist_counter.sv
// Loadable down-counter with zero flag; times both INIT and RUN phases.
module bist_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: IDLE/INIT/RUN/FINISH over CHANNELS channels,
// with error capture, abort and a pass/fail result.
module bist_sequencer
   import bist_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                bist_start,
   input  logic [CNT_W-1:0]    run_len,
   input  logic [CHANNELS-1:0] ch_enable,
   input  logic [CHANNELS-1:0] ch_error,
   input  logic                abort,
   output logic                mode,
   output logic                init,
   output logic                running,
   output logic                finish,
   output logic                bist_end,
   output logic                pass,
   output logic [CHANNELS-1:0] fail_mask,
   output logic                aborted,
   output logic [CNT_W-1:0]    cycle_count
);

   localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES - 1);

   state_t              state;
   state_t              nxt;
   logic [CNT_W-1:0]    len_q;
   logic [CHANNELS-1:0] en_q;
   logic                accept;
   logic                active;
   logic                cnt_load;
   logic                cnt_dec;
   logic                cnt_zero;
   logic [CNT_W-1:0]    cnt_val;
   logic [CNT_W-1:0]    cnt;
   logic [CHANNELS-1:0] fm_nxt;
   logic                ab_nxt;

   assign accept = (state == st_idle) && bist_start;
   assign active = (state == st_init) || (state == st_run);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= st_idle;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         st_idle: if (bist_start) nxt = st_init;
         st_init: begin
            if (abort) begin
               nxt = st_fin;
            end else if (cnt_zero) begin
               nxt = (len_q == '0) ? st_fin : st_run;
            end
         end
         st_run:  if (abort || cnt_zero) nxt = st_fin;
         st_fin:  if (!bist_start) nxt = st_idle;
         default: nxt = st_idle;
      endcase
   end

   always_comb begin
      mode    = 1'b0;
      init    = 1'b0;
      running = 1'b0;
      finish  = 1'b0;
      unique case (1'b1)
         (state == st_init): init    = 1'b1;
         (state == st_run):  running = 1'b1;
         (state == st_fin):  finish  = 1'b1;
         default:            mode    = 1'b0;
      endcase
      mode = (state != st_idle);
   end

   // Reload for RUN on the last INIT cycle unless aborting or run_len is 0
   assign cnt_load = accept ||
                     ((state == st_init) && cnt_zero && !abort &&
                      (len_q != '0));
   assign cnt_val  = accept ? INIT_LOAD : (len_q - 1'b1);
   assign cnt_dec  = active;

   bist_counter #(.W(CNT_W)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   assign fm_nxt = (state == st_run) ?
                   (fail_mask | (ch_error & en_q)) : fail_mask;
   assign ab_nxt = aborted | (active & abort);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         len_q       <= '0;
         en_q        <= '0;
         fail_mask   <= '0;
         aborted     <= 1'b0;
         cycle_count <= '0;
         pass        <= 1'b0;
         bist_end    <= 1'b0;
      end else begin
         bist_end <= (nxt == st_fin) && (state != st_fin);
         if (accept) begin
            len_q       <= run_len;
            en_q        <= ch_enable;
            fail_mask   <= '0;
            aborted     <= 1'b0;
            cycle_count <= '0;
            pass        <= 1'b0;
         end else begin
            fail_mask <= fm_nxt;
            aborted   <= ab_nxt;
            if (state == st_run && cycle_count != '1) begin
               cycle_count <= cycle_count + 1'b1;
            end
            if (nxt == st_fin) begin
               pass <= (fm_nxt == '0) && !ab_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: phase timing, errors, abort,
// async reset and start-hold behaviour.
module tb_bist_sequencer;

   logic        clock;
   logic        reset;
   logic        bist_start;
   logic [15:0] run_len;
   logic [3:0]  ch_enable;
   logic [3:0]  ch_error;
   logic        abort;
   logic        mode;
   logic        init;
   logic        running;
   logic        finish;
   logic        bist_end;
   logic        pass;
   logic [3:0]  fail_mask;
   logic        aborted;
   logic [15:0] cycle_count;

   int n_checks = 0;
   int n_errors = 0;
   int n_init;
   int n_run;
   int n_end;
   int end_at;

   bist_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .bist_start  (bist_start),
      .run_len     (run_len),
      .ch_enable   (ch_enable),
      .ch_error    (ch_error),
      .abort       (abort),
      .mode        (mode),
      .init        (init),
      .running     (running),
      .finish      (finish),
      .bist_end    (bist_end),
      .pass        (pass),
      .fail_mask   (fail_mask),
      .aborted     (aborted),
      .cycle_count (cycle_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Call at a negedge; cycle k is the k-th cycle after the accept edge.
   task automatic run_test(input logic [15:0] len, input logic [3:0] en,
                           input logic [3:0] ea, input logic [3:0] el,
                           input int ak, input int ncyc, input bit hold);
      n_init = 0;
      n_run  = 0;
      n_end  = 0;
      end_at = -1;
      run_len    = len;
      ch_enable  = en;
      ch_error   = 4'h0;
      abort      = 1'b0;
      bist_start = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clock);
         if (init) n_init++;
         if (running) n_run++;
         if (bist_end) begin
            n_end++;
            if (end_at < 0) end_at = k;
         end
         if (k == 1) begin
            run_len   = 16'd3;
            ch_enable = 4'h0;
            if (!hold) bist_start = 1'b0;
         end
         if (k <= 4) ch_error = 4'hF;
         else if (k < 4 + int'(len)) ch_error = ea;
         else if (k == 4 + int'(len)) ch_error = ea | el;
         else ch_error = 4'hF;
         abort = (ak > 0) && (k >= ak);
      end
      ch_error = 4'h0;
      abort    = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      bist_start = 1'b0;
      run_len    = 16'd0;
      ch_enable  = 4'h0;
      ch_error   = 4'h0;
      abort      = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_mode", mode, 0);
      check("rst_pass", pass, 0);
      check("rst_cc", cycle_count, 0);
      check("rst_fm", fail_mask, 0);
      reset = 1'b1;
      @(negedge clock);

      run_test(16'd8, 4'hF, 4'h0, 4'h0, 0, 16, 0);
      check("t1_init", n_init, 4);
      check("t1_run", n_run, 8);
      check("t1_end_at", end_at, 13);
      check("t1_nend", n_end, 1);
      check("t1_pass", pass, 1);
      check("t1_cc", cycle_count, 8);
      check("t1_fm", fail_mask, 0);
      check("t1_ab", aborted, 0);
      check("t1_idle", mode, 0);

      run_test(16'd5, 4'b1011, 4'b0100, 4'b0001, 0, 12, 0);
      check("t2_fm", fail_mask, 4'b0001);
      check("t2_pass", pass, 0);
      check("t2_cc", cycle_count, 5);
      check("t2_end_at", end_at, 10);

      run_test(16'd0, 4'hF, 4'h0, 4'h0, 0, 8, 0);
      check("t3_run", n_run, 0);
      check("t3_init", n_init, 4);
      check("t3_end_at", end_at, 5);
      check("t3_pass", pass, 1);
      check("t3_cc", cycle_count, 0);

      run_test(16'd20, 4'hF, 4'h0, 4'h0, 10, 14, 1);
      check("t4_end_at", end_at, 11);
      check("t4_nend", n_end, 1);
      check("t4_run", n_run, 6);
      check("t4_ab", aborted, 1);
      check("t4_pass", pass, 0);
      check("t4_cc", cycle_count, 6);
      check("t4_fin", finish, 1);
      bist_start = 1'b0;
      @(negedge clock);
      check("t4_idle", mode, 0);

      run_len    = 16'd20;
      ch_enable  = 4'hF;
      bist_start = 1'b1;
      @(negedge clock);
      bist_start = 1'b0;
      ch_error   = 4'h2;
      repeat (7) @(negedge clock);
      check("t5_running", running, 1);
      check("t5_fm_pre", fail_mask, 4'h2);
      #2 reset = 1'b0;
      #1;
      check("t5_mode", mode, 0);
      check("t5_running0", running, 0);
      check("t5_cc", cycle_count, 0);
      check("t5_fm", fail_mask, 0);
      check("t5_end", bist_end, 0);
      ch_error = 4'h0;
      @(negedge clock);
      reset = 1'b1;
      n_end = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (bist_end || mode) n_end++;
      end
      check("t5_quiet", n_end, 0);
      run_test(16'd8, 4'hF, 4'h0, 4'h0, 0, 16, 0);
      check("t5_end_at", end_at, 13);
      check("t5_cc_after", cycle_count, 8);
      check("t5_pass", pass, 1);

      run_test(16'd2, 4'hF, 4'h0, 4'b0010, 0, 12, 1);
      check("t6_end_at", end_at, 7);
      check("t6_nend", n_end, 1);
      check("t6_init", n_init, 4);
      check("t6_fin", finish, 1);
      check("t6_fm", fail_mask, 4'b0010);
      check("t6_pass", pass, 0);
      bist_start = 1'b0;
      @(negedge clock);
      check("t6_idle", mode, 0);
      check("t6_fm_hold", fail_mask, 4'b0010);
      run_len    = 16'd2;
      ch_enable  = 4'hF;
      bist_start = 1'b1;
      @(negedge clock);
      check("t6_reinit", init, 1);
      check("t6_fm_clr", fail_mask, 0);
      bist_start = 1'b0;
      repeat (12) @(negedge clock);
      check("t6_pass2", pass, 1);
      check("t6_cc2", cycle_count, 2);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bist_sequencer.md
# bist_sequencer

Parametrised built-in-self-test sequencer: next generation of the single-channel BIST state machine, driving CHANNELS test channels through INIT, RUN and FINISH phases. Adds per-channel enable and error capture, a programmable run length, abort, and a pass/fail result. Sits between the top-level test controller, which drives `bist_start`, and the per-channel BIST engines, which return `ch_error`.

## Interface
- CHANNELS, 4: number of test channels, ≥1.
- CNT_W, 16: width of the run-length and cycle counter.
- INIT_CYCLES, 4: length of the INIT phase in cycles, ≥1.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- bist_start  in  1  level request; accepted in IDLE; must drop before the next test.
- run_len  in  CNT_W  RUN phase length in cycles; latched on accept.
- ch_enable  in  CHANNELS  channel mask; latched on accept.
- ch_error  in  CHANNELS  per-channel error, sampled every RUN cycle.
- abort  in  1  terminates INIT/RUN early.
- mode  out  1  test mode; high in every non-IDLE state.
- init  out  1  high in INIT.
- running  out  1  high in RUN.
- finish  out  1  high in FINISH.
- bist_end  out  1  one-cycle pulse on the first FINISH cycle.
- pass  out  1  valid in FINISH and after; 1 = no enabled errors and not aborted.
- fail_mask  out  CHANNELS  sticky per-channel error flags.
- aborted  out  1  last test was aborted.
- cycle_count  out  CNT_W  RUN cycles completed in the current or last test.

## Operation
- States: IDLE, INIT, RUN, FINISH. All outputs are registered and depend on state only (Moore).
- IDLE, bist_start=1: go to INIT. Latch run_len and ch_enable. Clear fail_mask, aborted, cycle_count and pass.
- INIT: lasts exactly INIT_CYCLES cycles. Then go to RUN, or to FINISH if the latched run_len=0.
- RUN: lasts exactly run_len cycles.
  - cycle_count increments once per RUN cycle.
  - fail_mask |= ch_error & ch_enable_q on every RUN cycle, including the last.
- FINISH: pass = (fail_mask==0) & ~aborted. Stay until bist_start=0, then go to IDLE.
- Results (pass, fail_mask, aborted, cycle_count) hold through IDLE until the next accept.
- abort in INIT or RUN: go to FINISH next cycle and set aborted=1. An error sampled in the same RUN cycle is still recorded.
  - abort takes priority over normal end-of-run.
  - abort is ignored in IDLE and FINISH.
- ch_error outside RUN is ignored. Disabled channels never set fail_mask.
- cycle_count never wraps: maximum is 2^CNT_W−1 = maximum run_len.
- run_len and ch_enable changes after accept have no effect.
- Reset mid-test: state goes to IDLE immediately (asynchronous). All outputs clear and no bist_end is generated.

## Timing
- Reset values: all outputs 0, including pass; state IDLE.
- bist_start is sampled high at edge t. Then:
  - init is high for cycles t+1 … t+INIT_CYCLES.
  - running is high for the next run_len cycles.
  - bist_end and finish rise on cycle t+1+INIT_CYCLES+run_len.
- Latency from accept to bist_end is INIT_CYCLES+run_len+1 edges.
- A ch_error sampled on RUN cycle k appears in fail_mask on cycle k+1.
- abort sampled at edge a gives FINISH and bist_end at cycle a+1.
- bist_end lasts exactly one cycle even if bist_start stays high.
- FINISH→IDLE takes one cycle after bist_start=0. A new accept needs bist_start low for at least one sampled edge.

## Structure
- Package bist_pkg holds:
  - the state typedef and encoding (IDLE=0, INIT=1, RUN=2, FINISH=3);
  - default parameter constants.
- Sub-module bist_counter: loadable down-counter with a zero flag, shared by the INIT and RUN phase timing. The top level keeps the FSM, the latches, fail_mask and cycle_count.

## Test plan
- Defaults, run_len=8, ch_enable=4'hF, no errors:
  - init high 4 cycles, running high 8 cycles;
  - bist_end pulses once 13 cycles after accept;
  - pass=1, cycle_count=8.
- run_len=5, ch_enable=4'b1011, ch_error=4'b0100 on every RUN cycle and 4'b0001 on the last RUN cycle only:
  - fail_mask=4'b0001, pass=0.
- run_len=0: INIT then FINISH directly; running never high; bist_end 5 cycles after accept; pass=1; cycle_count=0.
- run_len=20, abort on RUN cycle 6:
  - FINISH on the next cycle, aborted=1, pass=0, cycle_count=6;
  - abort held during FINISH has no effect.
- reset driven low mid-RUN, asynchronously:
  - all outputs 0 before the next edge, state IDLE, no bist_end;
  - a new start after release runs normally.
- bist_start held high through FINISH: no restart, single bist_end. Drop bist_start, then raise it again: IDLE then INIT, fail_mask cleared.
